// File: rtl/inpdt_seq.sv
// inpdt_seq: walks every (row, chunk) of one matrix-vector job through the
// inner-product unit, sums chunk results per row and hands each row sum downstream.
module inpdt_seq #(
    parameter int N_ROW   = 32,
    parameter int N_CHUNK = 4,
    parameter int ROW_AW  = 5,
    parameter int CHK_AW  = 2,
    parameter int ACC_W   = 26
) (
    input  logic                     iClk,
    input  logic                     iRstn,
    input  logic                     iStart,
    output logic                     oBusy,
    output logic                     oDone,
    output logic                     oRd_en,
    output logic [ROW_AW+CHK_AW-1:0] oW_addr,
    output logic [CHK_AW-1:0]        oXH_addr,
    output logic                     oInpdt_en,
    input  logic [20:0]              iInpdt_result,
    output logic                     oAcc_valid,
    input  logic                     iAcc_ready,
    output logic [ACC_W-1:0]         oAcc_data,
    output logic [ROW_AW-1:0]        oAcc_row
);
    localparam int AW = ROW_AW + CHK_AW;

    typedef enum logic [2:0] {IDLE, RUN, FLUSH, WAIT_OUT, DONE} state_t;
    state_t state, state_nxt;

    logic [ROW_AW-1:0]       row;
    logic [CHK_AW-1:0]       chunk;
    logic                    last_chunk, last_row, out_free, issue;
    logic                    vld_p1, first_p1, last_p1;
    logic [ROW_AW-1:0]       row_p1;
    logic signed [ACC_W-1:0] acc, sum_p1, acc_data;
    logic                    acc_valid;
    logic [ROW_AW-1:0]       acc_row;

    function automatic logic signed [ACC_W-1:0] sext_result(input logic [20:0] r);
        return ACC_W'($signed(r));
    endfunction

    assign last_chunk = (chunk == CHK_AW'(N_CHUNK - 1));
    assign last_row   = (row == ROW_AW'(N_ROW - 1));
    // Output register is empty or drains this cycle, so a row load two cycles out is safe.
    assign out_free   = !acc_valid || iAcc_ready;
    assign issue      = (state == RUN) && (!last_chunk || out_free);

    always_ff @(posedge iClk or negedge iRstn) begin
        if (!iRstn) state <= IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:     if (iStart) state_nxt = RUN;
            RUN:      if (issue && last_chunk && last_row) state_nxt = FLUSH;
            FLUSH:    state_nxt = WAIT_OUT;
            WAIT_OUT: if (out_free) state_nxt = DONE;
            DONE:     state_nxt = IDLE;
            default:  state_nxt = IDLE;
        endcase
    end

    always_comb begin
        oBusy    = (state != IDLE);
        oDone    = (state == DONE);
        oRd_en   = issue;
        oW_addr  = AW'(row) * AW'(N_CHUNK) + AW'(chunk);
        oXH_addr = chunk;
    end

    always_ff @(posedge iClk or negedge iRstn) begin
        if (!iRstn) begin
            row   <= '0;
            chunk <= '0;
        end else if (state == IDLE && iStart) begin
            row   <= '0;
            chunk <= '0;
        end else if (issue) begin
            if (last_chunk) begin
                chunk <= '0;
                row   <= last_row ? '0 : row + ROW_AW'(1);
            end else begin
                chunk <= chunk + CHK_AW'(1);
            end
        end
    end

    // stage p1: the unit evaluates the chunk issued last cycle
    always_ff @(posedge iClk or negedge iRstn) begin
        if (!iRstn) begin
            vld_p1   <= 1'b0;
            first_p1 <= 1'b0;
            last_p1  <= 1'b0;
            row_p1   <= '0;
        end else begin
            vld_p1   <= issue;
            first_p1 <= (chunk == '0);
            last_p1  <= last_chunk;
            row_p1   <= row;
        end
    end

    assign oInpdt_en = vld_p1;

    always_comb begin
        sum_p1 = sext_result(iInpdt_result);
        if (!first_p1) sum_p1 = sum_p1 + acc;
    end

    always_ff @(posedge iClk or negedge iRstn) begin
        if (!iRstn)                 acc <= '0;
        else if (vld_p1 && !last_p1) acc <= sum_p1;
    end

    // The last chunk's sum bypasses acc and lands in the output register; a load beats a clear.
    always_ff @(posedge iClk or negedge iRstn) begin
        if (!iRstn) begin
            acc_valid <= 1'b0;
            acc_data  <= '0;
            acc_row   <= '0;
        end else if (vld_p1 && last_p1) begin
            acc_valid <= 1'b1;
            acc_data  <= sum_p1;
            acc_row   <= row_p1;
        end else if (acc_valid && iAcc_ready) begin
            acc_valid <= 1'b0;
        end
    end

    assign oAcc_valid = acc_valid;
    assign oAcc_data  = acc_data;
    assign oAcc_row   = acc_row;

endmodule

// File: tb/tb_inpdt_seq.sv
// Self-checking bench for inpdt_seq: a job-level reference model checked every cycle,
// plus directed scenarios with hand-computed expectations.
module tb_inpdt_seq;
    localparam int R = 4, C = 4, RAW = 2, CAW = 2, ACCW = 26, RC = R * C;

    logic              clk = 1'b0;
    logic              rst_n;
    logic              iStart, iAcc_ready;
    logic [20:0]       iInpdt_result;
    logic              oBusy, oDone, oRd_en, oInpdt_en, oAcc_valid;
    logic [RAW+CAW-1:0] oW_addr;
    logic [CAW-1:0]    oXH_addr;
    logic [ACCW-1:0]   oAcc_data;
    logic [RAW-1:0]    oAcc_row;

    always #5 clk = ~clk;

    inpdt_seq #(.N_ROW(R), .N_CHUNK(C), .ROW_AW(RAW), .CHK_AW(CAW), .ACC_W(ACCW)) dut (
        .iClk(clk), .iRstn(rst_n), .iStart(iStart), .oBusy(oBusy), .oDone(oDone),
        .oRd_en(oRd_en), .oW_addr(oW_addr), .oXH_addr(oXH_addr), .oInpdt_en(oInpdt_en),
        .iInpdt_result(iInpdt_result), .oAcc_valid(oAcc_valid), .iAcc_ready(iAcc_ready),
        .oAcc_data(oAcc_data), .oAcc_row(oAcc_row)
    );

    int checks = 0, errors = 0;
    int cyc = 0, done_seen = 0, start_cyc = 0, first_rd_cyc = -1, done_cyc = 0;
    logic [ACCW-1:0] got [R];

    // Job-level model: issue index k walks 0..RC-1, row = k/C, chunk = k%C.
    logic            m_busy, m_run, m_inflight, m_valid, m_all_loaded, m_done_now;
    int              m_k, m_fk, m_row;
    longint          m_psum;
    logic [ACCW-1:0] m_data;

    task automatic chk(input string name, input longint act, input longint exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    function automatic longint all_outs();
        return longint'({oBusy, oDone, oRd_en, oW_addr, oXH_addr, oInpdt_en,
                         oAcc_valid, oAcc_data, oAcc_row});
    endfunction

    always @(negedge clk) begin
        logic e_rd, load, next_done, busy_t;
        cyc++;
        if (!rst_n) begin
            chk("reset_outputs", all_outs(), 0);
            m_busy = 0; m_run = 0; m_inflight = 0; m_valid = 0; m_all_loaded = 0;
            m_done_now = 0; m_k = 0; m_fk = 0; m_row = 0; m_psum = 0; m_data = '0;
        end else begin
            e_rd = m_run && m_k < RC && !((m_k % C) == C - 1 && m_valid && !iAcc_ready);
            chk("busy", longint'(oBusy), longint'(m_busy));
            chk("rd_en", longint'(oRd_en), longint'(e_rd));
            chk("inpdt_en", longint'(oInpdt_en), longint'(m_inflight));
            chk("done", longint'(oDone), longint'(m_done_now));
            chk("acc_valid", longint'(oAcc_valid), longint'(m_valid));
            if (e_rd) begin
                chk("w_addr", longint'(oW_addr), longint'(m_k));
                chk("xh_addr", longint'(oXH_addr), longint'(m_k % C));
            end
            if (m_valid) begin
                chk("acc_data", longint'(oAcc_data), longint'(m_data));
                chk("acc_row", longint'(oAcc_row), longint'(m_row));
            end
            if (oRd_en && first_rd_cyc < 0) first_rd_cyc = cyc;
            if (oDone) begin done_seen++; done_cyc = cyc; end
            if (oAcc_valid && iAcc_ready) got[oAcc_row] = oAcc_data;

            busy_t = m_busy;
            load = m_inflight && (m_fk % C) == C - 1;
            if (m_inflight) begin
                if (m_fk % C == 0) m_psum = 0;
                m_psum += longint'($signed(iInpdt_result));
            end
            next_done = m_busy && m_all_loaded && !m_done_now && (!m_valid || iAcc_ready);
            if (load) begin
                m_valid = 1; m_data = ACCW'(m_psum); m_row = m_fk / C;
                if (m_fk / C == R - 1) m_all_loaded = 1;
            end else if (m_valid && iAcc_ready) begin
                m_valid = 0;
            end
            if (m_done_now) begin m_busy = 0; m_all_loaded = 0; end
            m_done_now = next_done;
            m_inflight = e_rd;
            m_fk = m_k;
            if (e_rd) m_k++;
            if (m_k == RC) m_run = 0;
            if (!busy_t && iStart) begin
                m_busy = 1; m_run = 1; m_k = 0; start_cyc = cyc; first_rd_cyc = -1;
            end
        end
    end

    int   res_mode, rdy_mode;
    logic st_rand;

    task automatic step(input logic st);
        @(posedge clk);
        #1;
        iStart = st || (st_rand && oBusy && $urandom_range(0, 3) == 0);
        case (rdy_mode)
            0:       iAcc_ready = 1'($urandom_range(0, 1));
            1:       iAcc_ready = 1'b1;
            default: iAcc_ready = 1'b0;
        endcase
        if (!oInpdt_en)         iInpdt_result = '0;
        else if (res_mode == 0) iInpdt_result = 21'($urandom);
        else if (res_mode == 1) iInpdt_result = 21'd5;
        else                    iInpdt_result = 21'h100000;
    endtask

    task automatic wait_done(input int d0, input int budget);
        int n = 0;
        while (done_seen == d0 && n < budget) begin step(1'b0); n++; end
        chk("job_done", longint'(done_seen - d0), 1);
        repeat (4) step(1'b0);
        chk("single_done", longint'(done_seen - d0), 1);
        chk("idle_after", longint'(oBusy), 0);
    endtask

    task automatic run_job(input int budget);
        int d0 = done_seen;
        step(1'b1);
        wait_done(d0, budget);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        int d0;
        rst_n = 1'b1; iStart = 0; iAcc_ready = 0; iInpdt_result = '0;
        res_mode = 1; rdy_mode = 1; st_rand = 0;
        #1 rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        step(1'b0);

        // Constant +5 per chunk, always ready: each row sums to 20, fixed latency.
        for (int i = 0; i < R; i++) got[i] = '1;
        run_job(200);
        chk("first_rd_latency", longint'(first_rd_cyc - start_cyc), 1);
        chk("done_latency", longint'(done_cyc - start_cyc), RC + 3);
        for (int i = 0; i < R; i++) chk("row_sum_5", longint'(got[i]), 20);

        // Most negative 21-bit result in every chunk: 4 * -1048576, sign-extended.
        res_mode = 2;
        for (int i = 0; i < R; i++) got[i] = '0;
        run_job(200);
        for (int i = 0; i < R; i++) chk("row_sum_min", longint'(got[i]), longint'(26'h3C00000));

        // Downstream stalled from the start: row 1's last chunk must wait.
        res_mode = 0; rdy_mode = 2;
        d0 = done_seen;
        step(1'b1);
        repeat (11) step(1'b0);
        chk("stall_rd_en", longint'(oRd_en), 0);
        chk("stall_w_addr", longint'(oW_addr), 7);
        chk("stall_xh_addr", longint'(oXH_addr), 3);
        chk("stall_valid", longint'(oAcc_valid), 1);
        chk("stall_row", longint'(oAcc_row), 0);
        rdy_mode = 1; iAcc_ready = 1'b1;
        #1;
        chk("resume_rd_en", longint'(oRd_en), 1);
        wait_done(d0, 200);

        // Reset while issuing row 1, then a fresh job.
        d0 = done_seen;
        step(1'b1);
        repeat (5) step(1'b0);
        chk("pre_reset_addr", longint'(oW_addr), 4);
        rst_n = 1'b0;
        #1;
        chk("reset_async", all_outs(), 0);
        step(1'b0);
        step(1'b0);
        rst_n = 1'b1;
        repeat (3) step(1'b0);
        chk("no_done_after_reset", longint'(done_seen - d0), 0);
        run_job(200);
        chk("fresh_done_latency", longint'(done_cyc - start_cyc), RC + 3);

        // Random results, random back-pressure, stray iStart pulses while busy.
        rdy_mode = 0; st_rand = 1;
        for (int j = 0; j < 8; j++) run_job(600);
        st_rand = 0;

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
